// File: rtl/qei_decoder_if.sv
// Quadrature decoder control/status bundle: raw encoder pads, controls and results.
interface qei_decoder_if #(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned VEL_W = 16
);
  logic             ch_a;
  logic             ch_b;
  logic             enable;
  logic             invert;
  logic             clear;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic             err_clr;
  logic [CNT_W-1:0] position;
  logic [VEL_W-1:0] velocity;
  logic             vel_valid;
  logic             dir;
  logic             err;

  // Controller side: drives pads/controls, observes results.
  modport master (
    output ch_a, ch_b, enable, invert, clear, load, load_val, err_clr,
    input  position, velocity, vel_valid, dir, err
  );

  // Decoder side.
  modport slave (
    input  ch_a, ch_b, enable, invert, clear, load, load_val, err_clr,
    output position, velocity, vel_valid, dir, err
  );
endinterface

// File: rtl/qei_decoder.sv
// Quadrature encoder front end: sync, glitch filter, 4x decode, position,
// windowed velocity and sticky illegal-transition flag.
module qei_decoder #(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned FILT_LEN   = 3,
  parameter int unsigned VEL_PERIOD = 100000,
  parameter int unsigned VEL_W      = 16
) (
  input  logic         clock,
  input  logic         reset_n,
  qei_decoder_if.slave bus
);

  localparam int unsigned FCNT_W  = $clog2(FILT_LEN + 1);
  localparam int unsigned INIT_W  = $clog2(FILT_LEN + 3);
  localparam int unsigned WIN_W   = $clog2(VEL_PERIOD);
  localparam int unsigned DELTA_W = $clog2(VEL_PERIOD + 1) + 1;
  localparam int unsigned SUM_W   = ((DELTA_W > VEL_W) ? DELTA_W : VEL_W) + 1;

  localparam logic signed [SUM_W-1:0] VEL_MAX = SUM_W'((64'sd1 <<< (VEL_W - 1)) - 64'sd1);
  localparam logic signed [SUM_W-1:0] VEL_MIN = SUM_W'(-(64'sd1 <<< (VEL_W - 1)));
  // Start-up settle: sync pipe plus filter must fill before prev is trusted.
  localparam logic [INIT_W-1:0]       INIT_CYCLES = INIT_W'(FILT_LEN + 2);

  // Bit 1 = channel A, bit 0 = channel B throughout.
  logic [1:0]              meta_q, meta_d, sync_q, sync_d, filt_q, filt_d, prev_q, prev_d;
  logic [1:0][FCNT_W-1:0]  fcnt_q, fcnt_d, fcnt_inc;
  logic [INIT_W-1:0]       init_q, init_d;
  logic [CNT_W-1:0]        position_q, position_d;
  logic signed [DELTA_W-1:0] delta_q, delta_d;
  logic [WIN_W-1:0]        win_q, win_d;
  logic [VEL_W-1:0]        velocity_q, velocity_d;
  logic                    vel_valid_q, vel_valid_d;
  logic                    dir_q, dir_d;
  logic                    err_q, err_d;

  logic                    fwd_raw, rev_raw, ill_raw;
  logic                    fwd_c, rev_c, ill_c, up_c, dn_c, win_end_c;
  logic signed [SUM_W-1:0] step_c, sum_c;

  // Synchroniser and per-channel stable-sample filter.
  always_comb begin
    meta_d   = {bus.ch_a, bus.ch_b};
    sync_d   = meta_q;
    filt_d   = filt_q;
    fcnt_d   = fcnt_q;
    fcnt_inc = fcnt_q;
    for (int i = 0; i < 2; i++) begin
      // A run of differing samples starts fresh whenever the previous sample matched.
      fcnt_inc[i] = (sync_q[i] == filt_q[i]) ? FCNT_W'(1) : fcnt_q[i] + FCNT_W'(1);
      if (sync_d[i] == filt_q[i]) begin
        fcnt_d[i] = '0;
      end else if (fcnt_inc[i] == FCNT_W'(FILT_LEN)) begin
        filt_d[i] = sync_d[i];
        fcnt_d[i] = '0;
      end else begin
        fcnt_d[i] = fcnt_inc[i];
      end
    end
  end

  // Gray-code transition decode against the previous filtered state.
  always_comb begin
    fwd_raw = 1'b0;
    rev_raw = 1'b0;
    ill_raw = 1'b0;
    case ({prev_q, filt_q})
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: fwd_raw = 1'b1;
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: rev_raw = 1'b1;
      4'b00_11, 4'b11_00, 4'b10_01, 4'b01_10: ill_raw = 1'b1;
      default: ;
    endcase
    fwd_c  = (init_q == '0) & (bus.invert ? rev_raw : fwd_raw);
    rev_c  = (init_q == '0) & (bus.invert ? fwd_raw : rev_raw);
    ill_c  = (init_q == '0) & ill_raw;
    up_c   = bus.enable & fwd_c;
    dn_c   = bus.enable & rev_c;
    prev_d = filt_q;
    init_d = (init_q == '0) ? init_q : init_q - INIT_W'(1);
  end

  // Position, direction, error flag and velocity window.
  always_comb begin
    position_d  = position_q;
    dir_d       = dir_q;
    err_d       = err_q;
    velocity_d  = velocity_q;
    vel_valid_d = 1'b0;
    step_c      = '0;
    if (up_c) step_c = SUM_W'(1);
    else if (dn_c) step_c = '1;
    sum_c       = SUM_W'(delta_q) + step_c;
    delta_d     = DELTA_W'(sum_c);
    win_end_c   = (win_q == WIN_W'(VEL_PERIOD - 1));
    win_d       = win_q + WIN_W'(1);

    if (bus.clear)      position_d = '0;
    else if (bus.load)  position_d = bus.load_val;
    else if (up_c)      position_d = position_q + CNT_W'(1);
    else if (dn_c)      position_d = position_q - CNT_W'(1);

    if (fwd_c)      dir_d = 1'b1;
    else if (rev_c) dir_d = 1'b0;

    if (ill_c)            err_d = 1'b1;
    else if (bus.err_clr) err_d = 1'b0;

    if (win_end_c) begin
      win_d       = '0;
      delta_d     = '0;
      vel_valid_d = 1'b1;
      if (sum_c > VEL_MAX)      velocity_d = VEL_W'(VEL_MAX);
      else if (sum_c < VEL_MIN) velocity_d = VEL_W'(VEL_MIN);
      else                      velocity_d = VEL_W'(sum_c);
    end
  end

  // State registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta_q      <= '0;
      sync_q      <= '0;
      filt_q      <= '0;
      fcnt_q      <= '0;
      prev_q      <= '0;
      init_q      <= INIT_CYCLES;
      position_q  <= '0;
      delta_q     <= '0;
      win_q       <= '0;
      velocity_q  <= '0;
      vel_valid_q <= 1'b0;
      dir_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      meta_q      <= meta_d;
      sync_q      <= sync_d;
      filt_q      <= filt_d;
      fcnt_q      <= fcnt_d;
      prev_q      <= prev_d;
      init_q      <= init_d;
      position_q  <= position_d;
      delta_q     <= delta_d;
      win_q       <= win_d;
      velocity_q  <= velocity_d;
      vel_valid_q <= vel_valid_d;
      dir_q       <= dir_d;
      err_q       <= err_d;
    end
  end

  assign bus.position  = position_q;
  assign bus.velocity  = velocity_q;
  assign bus.vel_valid = vel_valid_q;
  assign bus.dir       = dir_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_qei_decoder.sv
// Bench for qei_decoder: directed scenarios plus random pad activity, all
// compared each cycle against a sample-history reference model.
module tb_qei_decoder;

  localparam int unsigned CNT_W      = 32;
  localparam int unsigned FILT_LEN   = 3;
  localparam int unsigned VEL_PERIOD = 100;
  localparam int unsigned VEL_W      = 4;
  localparam int          SETTLE     = FILT_LEN + 2;
  localparam int          VMAX       = (1 << (VEL_W - 1)) - 1;
  localparam int          VMIN       = -(1 << (VEL_W - 1));

  logic clock;
  logic reset_n;

  qei_decoder_if #(.CNT_W(CNT_W), .VEL_W(VEL_W)) bus ();

  qei_decoder #(
    .CNT_W(CNT_W), .FILT_LEN(FILT_LEN), .VEL_PERIOD(VEL_PERIOD), .VEL_W(VEL_W)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_chk;
  int n_fail;
  logic [1:0] ab;

  // Reference model state
  logic [1:0]       m_meta;
  logic [1:0]       m_hist [FILT_LEN];
  logic [1:0]       m_filt;
  logic [1:0]       m_prev;
  int               m_edges;
  logic [CNT_W-1:0] m_pos;
  int               m_delta;
  logic [VEL_W-1:0] m_vel;
  logic             m_vv;
  logic             m_dir;
  logic             m_err;

  // Position of a pad state along the forward cycle 00,10,11,01.
  function automatic int gidx(input logic [1:0] s);
    case (s)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] gcode(input int idx);
    case (idx)
      0:       return 2'b00;
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  task automatic model_reset();
    m_meta  = '0;
    for (int i = 0; i < FILT_LEN; i++) m_hist[i] = '0;
    m_filt  = '0;
    m_prev  = '0;
    m_edges = 0;
    m_pos   = '0;
    m_delta = 0;
    m_vel   = '0;
    m_vv    = 1'b0;
    m_dir   = 1'b0;
    m_err   = 1'b0;
  endtask

  // One rising edge of the model, using the inputs as seen at that edge.
  task automatic model_edge();
    int  d;
    int  step;
    int  sum;
    bit  fwd;
    bit  rev;
    bit  ill;
    bit  all_flip;
    fwd  = 1'b0;
    rev  = 1'b0;
    ill  = 1'b0;
    step = 0;
    if (m_edges >= SETTLE) begin
      d   = (gidx(m_filt) - gidx(m_prev) + 4) % 4;
      ill = (d == 2);
      fwd = bus.invert ? (d == 3) : (d == 1);
      rev = bus.invert ? (d == 1) : (d == 3);
    end
    m_prev = m_filt;
    if (fwd) m_dir = 1'b1;
    else if (rev) m_dir = 1'b0;
    if (ill) m_err = 1'b1;
    else if (bus.err_clr) m_err = 1'b0;
    if (bus.enable) step = fwd ? 1 : (rev ? -1 : 0);
    if (bus.clear) m_pos = '0;
    else if (bus.load) m_pos = bus.load_val;
    else m_pos = m_pos + CNT_W'(step);
    if ((m_edges % VEL_PERIOD) == VEL_PERIOD - 1) begin
      sum = m_delta + step;
      if (sum > VMAX) sum = VMAX;
      if (sum < VMIN) sum = VMIN;
      m_vel   = VEL_W'(sum);
      m_vv    = 1'b1;
      m_delta = 0;
    end else begin
      m_delta = m_delta + step;
      m_vv    = 1'b0;
    end
    // Filtered bit flips once the last FILT_LEN synchronised samples all disagree with it.
    for (int i = FILT_LEN - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = m_meta;
    for (int b = 0; b < 2; b++) begin
      all_flip = 1'b1;
      for (int i = 0; i < FILT_LEN; i++)
        if (m_hist[i][b] == m_filt[b]) all_flip = 1'b0;
      if (all_flip) m_filt[b] = ~m_filt[b];
    end
    m_meta  = {bus.ch_a, bus.ch_b};
    m_edges = m_edges + 1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    chk("position",  64'(bus.position),  64'(m_pos));
    chk("velocity",  64'(bus.velocity),  64'(m_vel));
    chk("vel_valid", 64'(bus.vel_valid), 64'(m_vv));
    chk("dir",       64'(bus.dir),       64'(m_dir));
    chk("err",       64'(bus.err),       64'(m_err));
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    compare_all();
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drive_ab(input logic [1:0] v);
    ab       = v;
    bus.ch_a = v[1];
    bus.ch_b = v[0];
  endtask

  task automatic step(input int dirn, input int hold_n);
    drive_ab(gcode((gidx(ab) + dirn + 4) % 4));
    hold(hold_n);
  endtask

  task automatic wait_vv(output int n, output bit seen);
    n    = 0;
    seen = 1'b0;
    while (n < 2 * VEL_PERIOD && !seen) begin
      tick();
      n++;
      if (bus.vel_valid === 1'b1) seen = 1'b1;
    end
    chk("vel_valid_wait", 64'(seen), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  n;
    bit  seen;
    int  r;
    int  h;
    n_chk        = 0;
    n_fail       = 0;
    reset_n      = 1'b0;
    bus.enable   = 1'b1;
    bus.invert   = 1'b0;
    bus.clear    = 1'b0;
    bus.load     = 1'b0;
    bus.load_val = '0;
    bus.err_clr  = 1'b0;
    drive_ab(2'b11);
    model_reset();
    repeat (2) @(negedge clock);
    chk("rst_position",  64'(bus.position),  64'd0);
    chk("rst_velocity",  64'(bus.velocity),  64'd0);
    chk("rst_vel_valid", 64'(bus.vel_valid), 64'd0);
    chk("rst_dir",       64'(bus.dir),       64'd0);
    chk("rst_err",       64'(bus.err),       64'd0);
    reset_n = 1'b1;

    // Inputs at 11 out of reset are absorbed silently
    hold(20);
    chk("t1_position", 64'(bus.position), 64'd0);
    chk("t1_err",      64'(bus.err),      64'd0);

    // Eight forward steps, then the same with invert
    for (int i = 0; i < 8; i++) step(1, 10);
    chk("t2_fwd_position", 64'(bus.position), 64'd8);
    chk("t2_fwd_dir",      64'(bus.dir),      64'd1);
    bus.invert = 1'b1;
    for (int i = 0; i < 8; i++) step(1, 10);
    chk("t2_inv_position", 64'(bus.position), 64'd0);
    chk("t2_inv_dir",      64'(bus.dir),      64'd0);
    bus.invert = 1'b0;

    // Short glitch is rejected; clean step lands on edge FILT_LEN+2
    bus.ch_a = ~ab[1];
    hold(2);
    bus.ch_a = ab[1];
    hold(10);
    chk("t3_glitch_position", 64'(bus.position), 64'd0);
    drive_ab(gcode((gidx(ab) + 1) % 4));
    hold(FILT_LEN + 1);
    chk("t3_latency_before", 64'(bus.position), 64'd0);
    tick();
    chk("t3_latency_at", 64'(bus.position), 64'd1);
    hold(5);

    // Illegal transitions and err_clr priority
    drive_ab(~ab);
    hold(10);
    chk("t4_err_set",      64'(bus.err),      64'd1);
    chk("t4_err_position", 64'(bus.position), 64'd1);
    drive_ab(~ab);
    hold(FILT_LEN + 1);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    chk("t4_err_set_wins", 64'(bus.err), 64'd1);
    hold(3);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    chk("t4_err_cleared", 64'(bus.err), 64'd0);

    // Load and wrap, then clear beats load beats count
    bus.load     = 1'b1;
    bus.load_val = 32'h7FFF_FFFF;
    tick();
    bus.load = 1'b0;
    chk("t5_load", 64'(bus.position), 64'h7FFF_FFFF);
    step(1, 10);
    chk("t5_wrap", 64'(bus.position), 64'h8000_0000);
    drive_ab(gcode((gidx(ab) + 1) % 4));
    hold(FILT_LEN + 1);
    bus.clear    = 1'b1;
    bus.load     = 1'b1;
    bus.load_val = 32'h1234_5678;
    tick();
    bus.clear = 1'b0;
    bus.load  = 1'b0;
    chk("t5_clear_wins", 64'(bus.position), 64'd0);
    hold(5);
    chk("t5_clear_hold", 64'(bus.position), 64'd0);

    // Asynchronous reset mid-operation
    step(1, 7);
    step(1, 3);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_position",  64'(bus.position),  64'd0);
    chk("arst_velocity",  64'(bus.velocity),  64'd0);
    chk("arst_vel_valid", 64'(bus.vel_valid), 64'd0);
    chk("arst_dir",       64'(bus.dir),       64'd0);
    chk("arst_err",       64'(bus.err),       64'd0);
    model_reset();
    drive_ab(2'b11);
    @(negedge clock);
    reset_n = 1'b1;
    hold(20);
    chk("arst_resume_position", 64'(bus.position), 64'd0);
    chk("arst_resume_err",      64'(bus.err),      64'd0);

    // Velocity window: saturation, period, enable=0 window
    wait_vv(n, seen);
    for (int i = 0; i < 12; i++) step(1, 5);
    wait_vv(n, seen);
    chk("t6_period", 64'(60 + n), 64'(VEL_PERIOD));
    chk("t6_velocity_sat", 64'(bus.velocity), 64'd7);
    bus.enable = 1'b0;
    tick();
    chk("t6_pulse_width", 64'(bus.vel_valid), 64'd0);
    for (int i = 0; i < 19; i++) step(1, 5);
    wait_vv(n, seen);
    chk("t6_period_2", 64'(96 + n), 64'(VEL_PERIOD));
    chk("t6_velocity_disabled", 64'(bus.velocity), 64'd0);
    bus.enable = 1'b1;

    // Random pad activity and control pulses against the model
    for (int it = 0; it < 400; it++) begin
      r            = int'($urandom_range(0, 9));
      h            = int'($urandom_range(1, 8));
      bus.enable   = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 15) == 0) bus.invert = ~bus.invert;
      bus.clear    = ($urandom_range(0, 19) == 0);
      bus.load     = ($urandom_range(0, 19) == 0);
      bus.err_clr  = ($urandom_range(0, 9) == 0);
      bus.load_val = $urandom;
      if (r < 6) drive_ab(gcode((gidx(ab) + (($urandom_range(0, 1) != 0) ? 1 : 3)) % 4));
      else if (r == 6) drive_ab(~ab);
      else if (r == 7) bus.ch_b = ~ab[0];
      tick();
      bus.clear   = 1'b0;
      bus.load    = 1'b0;
      bus.err_clr = 1'b0;
      if (r == 7 && h > 2) begin
        tick();
        bus.ch_b = ab[0];
        h = h - 1;
      end
      hold(h - 1);
      bus.ch_b = ab[0];
    end
    hold(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
